// File: rtl/pe_relay4.sv
// Four-port relay PE: per-input FIFOs, a programmable input->output route table
// and a round-robin arbiter feeding a one-word register on each output.

module pe_relay4_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  full
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_BITS-1:0] rd_ptr, wr_ptr;
    logic [DEPTH_BITS:0]   count;
    logic                  push_ok, pop_ok;

    assign full    = (count == (DEPTH_BITS+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end
endmodule

module pe_relay4 #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH_BITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ap_start,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_sel,
    input  logic [1:0]              cfg_dest,
    input  logic [4*DATA_WIDTH-1:0] in_data,
    input  logic [3:0]              in_valid,
    output logic [3:0]              in_ready,
    output logic [4*DATA_WIDTH-1:0] out_data,
    output logic [3:0]              out_valid,
    input  logic [3:0]              out_ready,
    output logic                    running
);
    logic [DATA_WIDTH-1:0] head [4];
    logic [1:0]            route [4];
    logic [1:0]            last_grant [4];
    logic [1:0]            gnt_idx [4];
    logic [3:0]            empty, full, pop, load, gnt_vld;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        pe_relay4_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_BITS(DEPTH_BITS)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (in_valid[i]),
            .wdata (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .pop   (pop[i]),
            .rdata (head[i]),
            .empty (empty[i]),
            .full  (full[i])
        );
    end

    assign in_ready = ~full;

    // Each input routes to exactly one output, so at most one output can pop it.
    always_comb begin
        logic [1:0] idx;
        pop = '0;
        idx = '0;
        for (int j = 0; j < 4; j++) begin
            load[j]    = running & (~out_valid[j] | out_ready[j]);
            gnt_vld[j] = 1'b0;
            gnt_idx[j] = last_grant[j];
            for (int k = 1; k <= 4; k++) begin
                idx = last_grant[j] + 2'(k);
                if (!gnt_vld[j] && !empty[idx] && route[idx] == 2'(j)) begin
                    gnt_vld[j] = 1'b1;
                    gnt_idx[j] = idx;
                end
            end
            if (load[j] && gnt_vld[j]) pop[gnt_idx[j]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running   <= 1'b0;
            out_valid <= '0;
            out_data  <= '0;
            route[0]  <= 2'd1;
            route[1]  <= 2'd0;
            route[2]  <= 2'd3;
            route[3]  <= 2'd2;
            for (int j = 0; j < 4; j++) last_grant[j] <= 2'd3;
        end else begin
            if (ap_start) running <= 1'b1;
            if (cfg_we && !running) route[cfg_sel] <= cfg_dest;
            for (int j = 0; j < 4; j++) begin
                if (load[j]) begin
                    out_valid[j] <= gnt_vld[j];
                    if (gnt_vld[j]) begin
                        out_data[j*DATA_WIDTH +: DATA_WIDTH] <= head[gnt_idx[j]];
                        last_grant[j] <= gnt_idx[j];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pe_relay4.sv
// Directed and randomized bench for pe_relay4 against a queue-level model of the relay.

module tb_pe_relay4;
    localparam int DW    = 128;
    localparam int DEPTH = 4;

    logic          clk, reset, ap_start, cfg_we, running;
    logic [1:0]    cfg_sel, cfg_dest;
    logic [4*DW-1:0] in_data, out_data;
    logic [3:0]    in_valid, in_ready, out_valid, out_ready;

    int n_chk = 0;
    int n_fail = 0;

    pe_relay4 #(.DATA_WIDTH(DW), .DEPTH_BITS(2)) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .cfg_we(cfg_we),
        .cfg_sel(cfg_sel), .cfg_dest(cfg_dest), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .running(running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: FIFO contents as arrays with element 0 at the head.
    logic [DW-1:0] mq [4][DEPTH];
    int            mcnt [4];
    int            mrt [4];
    int            mlg [4];
    bit            mrun;
    bit            mov [4];
    logic [DW-1:0] mod [4];

    function automatic void chk(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mcnt[i] = 0;
            mlg[i]  = 3;
            mov[i]  = 1'b0;
            mod[i]  = '0;
        end
        mrt[0] = 1; mrt[1] = 0; mrt[2] = 3; mrt[3] = 2;
        mrun = 1'b0;
    endtask

    task automatic model_step();
        int c0 [4];
        int g, idx;
        for (int i = 0; i < 4; i++) c0[i] = mcnt[i];
        for (int j = 0; j < 4; j++) begin
            if (mrun && (!mov[j] || out_ready[j])) begin
                g = -1;
                for (int k = 1; k <= 4; k++) begin
                    idx = (mlg[j] + k) % 4;
                    if (g < 0 && mcnt[idx] > 0 && mrt[idx] == j) g = idx;
                end
                if (g >= 0) begin
                    mod[j] = mq[g][0];
                    for (int s = 0; s < DEPTH-1; s++) mq[g][s] = mq[g][s+1];
                    mcnt[g]--;
                    mov[j] = 1'b1;
                    mlg[j] = g;
                end else begin
                    mov[j] = 1'b0;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (in_valid[i] && c0[i] < DEPTH) begin
                mq[i][mcnt[i]] = in_data[i*DW +: DW];
                mcnt[i]++;
            end
        end
        if (cfg_we && !mrun) mrt[cfg_sel] = int'(cfg_dest);
        if (ap_start) mrun = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid  = '0;
        cfg_we    = 1'b0;
        ap_start  = 1'b0;
        out_ready = 4'hF;
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                chk("in_ready", DW'(in_ready[i]), DW'(mcnt[i] < DEPTH));
                chk("out_valid", DW'(out_valid[i]), DW'(mov[i]));
                if (mov[i]) chk("out_data", out_data[i*DW +: DW], mod[i]);
            end
            chk("running", DW'(running), DW'(mrun));
        end
    end

    initial begin
        reset = 1'b0;
        in_data = '0;
        cfg_sel = '0;
        cfg_dest = '0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", DW'(in_ready), DW'(4'hF));
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_data_nz", DW'(out_data != '0), '0);
        chk("rst_running", DW'(running), '0);
        reset = 1'b1;

        // Single word east -> west, one cycle of latency after the push edge.
        ap_start = 1'b1; step(); ap_start = 1'b0;
        in_valid = 4'b0001; in_data[0 +: DW] = DW'(8'hA5); step();
        in_valid = '0; step();
        chk("pass_valid", DW'(out_valid), DW'(4'b0010));
        chk("pass_data", out_data[DW +: DW], DW'(8'hA5));
        step();
        chk("pass_single", DW'(out_valid), '0);

        // Fill north while idle, then drain in order on south.
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            in_valid = 4'b0100; in_data[2*DW +: DW] = DW'(n); step();
            if (n == 4) chk("north_full", DW'(in_ready[2]), '0);
        end
        in_valid = '0;
        ap_start = 1'b1; step(); ap_start = 1'b0;
        chk("start_running", DW'(running), DW'(1));
        chk("start_no_out", DW'(out_valid), '0);
        for (int n = 1; n <= 4; n++) begin
            step();
            chk("drain_valid", DW'(out_valid), DW'(4'b1000));
            chk("drain_data", out_data[3*DW +: DW], DW'(n));
        end
        step();
        chk("drain_done", DW'(out_valid), '0);

        // All inputs routed to east output: strict round-robin 0,1,2,3.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cfg_we = 1'b1; cfg_sel = 2'(i); cfg_dest = 2'd0; step();
        end
        cfg_we = 1'b0;
        for (int n = 0; n < 2; n++) begin
            in_valid = 4'hF;
            for (int i = 0; i < 4; i++) in_data[i*DW +: DW] = DW'(16*i + n);
            step();
        end
        in_valid = '0; out_ready = 4'b0001;
        ap_start = 1'b1; step(); ap_start = 1'b0;
        for (int n = 0; n < 8; n++) begin
            step();
            chk("rr_valid", DW'(out_valid[0]), DW'(1));
            chk("rr_data", out_data[0 +: DW], DW'(16*(n%4) + n/4));
        end
        step();
        chk("rr_done", DW'(out_valid), '0);

        // Backpressure on west output.
        do_reset();
        out_ready = 4'b1101;
        ap_start = 1'b1; step(); ap_start = 1'b0;
        in_valid = 4'b0001;
        for (int n = 0; n < 5; n++) begin
            in_data[0 +: DW] = DW'(256 + n); step();
            if (n >= 2) begin
                chk("stall_valid", DW'(out_valid[1]), DW'(1));
                chk("stall_data", out_data[DW +: DW], DW'(256));
            end
        end
        chk("stall_full", DW'(in_ready[0]), '0);
        in_valid = '0; out_ready = 4'hF;
        for (int n = 1; n <= 4; n++) begin
            step();
            chk("resume_data", out_data[DW +: DW], DW'(256 + n));
        end
        step();
        chk("resume_done", DW'(out_valid), '0);

        // Route writes ignored while running; reset drops buffered words.
        do_reset();
        ap_start = 1'b1; step(); ap_start = 1'b0;
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_dest = 2'd2; step(); cfg_we = 1'b0;
        in_valid = 4'b0001; in_data[0 +: DW] = DW'(8'h77); step();
        in_valid = '0; step();
        chk("lock_valid", DW'(out_valid), DW'(4'b0010));
        chk("lock_data", out_data[DW +: DW], DW'(8'h77));
        out_ready = 4'b0000;
        for (int n = 1; n <= 3; n++) begin
            in_valid = 4'b0100; in_data[2*DW +: DW] = DW'(n); step();
        end
        in_valid = '0; step();
        #2 reset = 1'b0; model_reset();
        #1;
        chk("async_out_valid", DW'(out_valid), '0);
        chk("async_in_ready", DW'(in_ready), DW'(4'hF));
        chk("async_running", DW'(running), '0);
        @(negedge clk);
        reset = 1'b1; out_ready = 4'hF;
        repeat (3) step();
        chk("post_rst_quiet", DW'(out_valid), '0);

        // Randomized traffic, including config attempts while running and a mid-run reset.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) do_reset();
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_sel  = 2'($urandom);
            cfg_dest = 2'($urandom);
            ap_start = (cyc == 200) || (cyc == 1600);
            in_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                in_data[i*DW +: DW] = rnd_word();
                out_ready[i] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        idle();
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_relay4.md
PE_RELAY4 -- requirements
Module: pe_relay4

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: payload bits per port word.
REQ-002 SHALL have parameter DEPTH_BITS, default 2: each input FIFO holds 2^DEPTH_BITS words.
REQ-003 SHALL use port index 0=east, 1=west, 2=north, 3=south for every packed bus; word i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-006 ap_start  input  1  start strobe; sampled high sets running.
REQ-007 cfg_we  input  1  route-table write enable.
REQ-008 cfg_sel  input  2  input port whose route is written.
REQ-009 cfg_dest  input  2  destination output port for cfg_sel.
REQ-010 in_data  input  4*DATA_WIDTH  input words per port.
REQ-011 in_valid  input  4  per-port input valid.
REQ-012 in_ready  output  4  per-port input ready.
REQ-013 out_data  output  4*DATA_WIDTH  output words per port.
REQ-014 out_valid  output  4  per-port output valid.
REQ-015 out_ready  input  4  per-port downstream ready.
REQ-016 running  output  1  forwarding enabled.

Function
REQ-017 SHALL give each input port an independent FIFO; push on rising edge when in_valid[i] & in_ready[i].
REQ-018 SHALL drive in_ready[i] = !full[i], independent of running and same-cycle pops; no push when full.
REQ-019 SHALL hold route[i] (2 bits) per input; reset values: route[0]=1, route[1]=0, route[2]=3, route[3]=2 (straight pass-through).
REQ-020 SHALL write route[cfg_sel]=cfg_dest on edge with cfg_we=1 and running=0; writes with running=1 ignored; route[i]==i (loopback) legal.
REQ-021 SHALL set running on first edge with ap_start=1; running cleared only by reset.
REQ-022 SHALL, while running=0, pop no FIFO and keep out_valid=0.
REQ-023 SHALL give each output j a one-word output register (out_valid[j], out_data word j) loaded when empty or when out_valid[j] & out_ready[j] on the same edge (full throughput, one word/cycle/output).
REQ-024 SHALL arbitrate output j among inputs i with FIFO non-empty and route[i]==j, round-robin: search starts at last_grant[j]+1 mod 4; last_grant[j] updates to the granted index on each load.
REQ-025 SHALL pop exactly the granted FIFO on a load; at most one pop per FIFO per cycle (each input routes to one output).
REQ-026 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-027 SHALL preserve per-input word order; no words lost or duplicated.
REQ-028 SHALL have latency: word accepted at edge k, empty FIFO and idle output, appears with out_valid=1 after edge k+1.
REQ-029 SHALL take route changes into effect for the FIFO head on the edge after the write.

Reset
REQ-030 SHALL on reset=0 clear all FIFO pointers/counts (in_ready=4'b1111 after release), out_valid=0, out_data=0, running=0, last_grant[j]=3, routes to REQ-019 values.
REQ-031 SHALL discard all buffered words on reset mid-operation; no output after release until new pushes and ap_start.

Verification
REQ-032 Reset, ap_start pulse, push 0xA5 on east at edge k, out_ready=1 -> west out_valid=1 with 0xA5 after edge k+1, single cycle.
REQ-033 Running=0, push 5 words on north, DEPTH_BITS=2 -> in_ready[2]=0 after 4th push, 5th not accepted; ap_start then drains 1,2,3,4 in order on south.
REQ-034 Routes all set to output 0 before start, all four FIFOs loaded, out_ready[0]=1 -> grants in order 0,1,2,3,0,... one word per cycle.
REQ-035 out_ready[1]=0 for 3 cycles with valid word -> out_data word 1 unchanged, east FIFO fills, resumes without loss.
REQ-036 cfg_we while running=1 -> route unchanged; reset asserted with 3 words buffered -> out_valid=0, in_ready=1111, running=0 immediately.
